tdm_demux81: RTL and testbench



---
 rtl/tdm_demux81.sv | 131 +++++++++++++
 tb/tb_tdm_demux81.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux81.sv
// tdm_demux81 -- receive end of an 8-slot TDM link.
//
// The transmitter is an 8:1 mux whose select lines come from a slot counter.
// This block keeps the same slot count, steers each slot sample into a shadow
// register, and publishes all 8 channels in parallel on Y when slot 7 arrives.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   en           slot strobe: one sample is present on D this cycle
//   sync         frame marker (slot 0), only meaningful with en
//   D            serial slot data, DW bits
//   S            next slot index expected (mirrors transmitter select)
//   Y            channel outputs, channel k = Y[k*DW +: DW]
//   frame_valid  one-cycle pulse: Y now holds a complete frame
//   sync_err     one-cycle pulse: framing error detected
//   locked       high while aligned to frames (FSM state LOCKED)
//
// Handshake: there is no backpressure. A sample is consumed on every rising
// edge where en=1; sync is sampled only on those same edges.

module tdm_demux81 #(
  parameter int unsigned          DW      = 1,
  parameter logic [8*DW-1:0]      RESET_Y = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            sync,
  input  logic [DW-1:0]   D,
  output logic [2:0]      S,
  output logic [8*DW-1:0] Y,
  output logic            frame_valid,
  output logic            sync_err,
  output logic            locked
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      s_q, s_d;
  logic [8*DW-1:0] y_q, y_d;
  logic            frame_valid_q, frame_valid_d;
  logic            sync_err_q, sync_err_d;

  // Slots 0..6 only: slot 7 goes straight from D into Y on the frame edge.
  logic [DW-1:0]   shadow_q [7];
  logic [DW-1:0]   shadow_d [7];

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    y_d           = y_q;
    shadow_d      = shadow_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          // Anything before the first sync is ignored.
          if (sync) begin
            shadow_d[0] = D;
            s_d         = 3'd1;
            state_d     = LOCKED;
          end
        end

        LOCKED: begin
          if (sync) begin
            // sync at S!=0 means the transmitter realigned: drop the
            // partial frame but stay locked and start over at slot 0.
            if (s_q != 3'd0) begin
              sync_err_d = 1'b1;
            end
            shadow_d[0] = D;
            s_d         = 3'd1;
          end else if (s_q == 3'd0) begin
            // Missing sync where a frame must start: lose lock.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else if (s_q == 3'd7) begin
            for (int k = 0; k < 7; k++) begin
              y_d[k*DW +: DW] = shadow_q[k];
            end
            y_d[7*DW +: DW] = D;
            frame_valid_d   = 1'b1;
            s_d             = 3'd0;
          end else begin
            shadow_d[s_q] = D;
            s_d           = s_q + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      s_q           <= 3'd0;
      y_q           <= RESET_Y;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      shadow_q      <= shadow_d;
    end
  end

  assign S           = s_q;
  assign Y           = y_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux81.sv
// Directed bench for tdm_demux81 (DW=1, RESET_Y=0).

module tb_tdm_demux81;

  logic       clk;
  logic       reset;
  logic       en;
  logic       sync;
  logic [0:0] d;
  logic [2:0] s;
  logic [7:0] y;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;

  int total;
  int bad;
  int fv_cnt;
  int se_cnt;

  tdm_demux81 #(.DW(1), .RESET_Y(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sync        (sync),
    .D           (d),
    .S           (s),
    .Y           (y),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic sy, input logic dv);
    @(negedge clk);
    en   = e;
    sync = sy;
    d    = dv;
    @(posedge clk);
    #1;
    fv_cnt += int'(frame_valid);
    se_cnt += int'(sync_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Full frame, sync on slot 0, bit k of v is slot k.
  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0), v[k]);
  endtask

  // Reset asserted with en=1 to show it overrides the slot strobe.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    sync  = 1'b0;
    d     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s",      32'(s),           32'd0);
    check("rst_y",      32'(y),           32'h00);
    check("rst_fv",     32'(frame_valid), 32'd0);
    check("rst_se",     32'(sync_err),    32'd0);
    check("rst_locked", 32'(locked),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; fv_cnt = 0; se_cnt = 0;
    reset = 1'b1; en = 1'b0; sync = 1'b0; d = 1'b0;
    repeat (2) @(posedge clk);
    pulse_reset();

    // Basic frame 1,0,1,1,0,0,1,0 -> 8'h4D
    fv_cnt = 0; se_cnt = 0;
    step(1'b1, 1'b1, 1'b1);
    check("first_locked", 32'(locked), 32'd1);
    check("first_s",      32'(s),      32'd1);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b1);
    check("pre7_fv", 32'(frame_valid), 32'd0);
    check("pre7_y",  32'(y),           32'h00);
    step(1'b1, 1'b0, 1'b0);
    check("f1_fv",     32'(frame_valid), 32'd1);
    check("f1_y",      32'(y),           32'h4D);
    check("f1_s",      32'(s),           32'd0);
    check("f1_locked", 32'(locked),      32'd1);
    idle(1);
    check("f1_fv_drop", 32'(frame_valid), 32'd0);
    check("f1_fv_cnt",  32'(fv_cnt),      32'd1);
    check("f1_se_cnt",  32'(se_cnt),      32'd0);

    // Samples before sync are ignored in HUNT
    pulse_reset();
    fv_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("hunt_s",      32'(s),      32'd0);
    check("hunt_locked", 32'(locked), 32'd0);
    send_frame(8'hFF);
    check("ff_y",   32'(y),      32'hFF);
    check("ff_cnt", 32'(fv_cnt), 32'd1);

    // Realignment mid-frame
    fv_cnt = 0; se_cnt = 0;
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    check("realign_pre_s", 32'(s), 32'd5);
    step(1'b1, 1'b1, 1'b0);
    check("realign_se",     32'(sync_err), 32'd1);
    check("realign_s",      32'(s),        32'd1);
    check("realign_locked", 32'(locked),   32'd1);
    check("realign_y_hold", 32'(y),        32'hFF);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    check("realign_y",      32'(y),        32'h00);
    check("realign_fv_cnt", 32'(fv_cnt),   32'd1);
    check("realign_se_cnt", 32'(se_cnt),   32'd1);
    check("realign_locked2", 32'(locked),  32'd1);

    // Missing sync at S=0 loses lock
    step(1'b1, 1'b0, 1'b1);
    check("lose_se",     32'(sync_err), 32'd1);
    check("lose_locked", 32'(locked),   32'd0);
    check("lose_s",      32'(s),        32'd0);
    check("lose_y",      32'(y),        32'h00);
    idle(1);
    check("lose_se_drop", 32'(sync_err), 32'd0);

    // Frame 8'h4D with en gaps of 0, 3 and 10 cycles; sync without en ignored
    fv_cnt = 0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("gap_sync_noen_s", 32'(s), 32'd3);
    idle(9);
    check("gap_y_hold", 32'(y),      32'h00);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("gap_fv_pre", 32'(fv_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("gap_fv", 32'(frame_valid), 32'd1);
    check("gap_y",  32'(y),           32'h4D);
    idle(5);
    check("gap_y_idle", 32'(y),      32'h4D);
    check("gap_cnt",    32'(fv_cnt), 32'd1);

    // Reset mid-frame at S=5, then a clean frame
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    check("mid_s", 32'(s), 32'd5);
    pulse_reset();
    fv_cnt = 0;
    send_frame(8'hA5);
    check("a5_y",   32'(y),      32'hA5);
    check("a5_cnt", 32'(fv_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
